// File: rtl/run_gen_pkg.sv
// rtl/run_gen_pkg.sv - shared state, command type and defaults for the run-length pattern generator
package run_gen_pkg;

  localparam int RG_CNT_W         = 8;
  localparam int RG_DETECT_THRESH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [RG_CNT_W-1:0] run;
    logic [RG_CNT_W-1:0] gap;
  } run_cmd_t;

endpackage

// File: rtl/run_cmd_slot.sv
// rtl/run_cmd_slot.sv - one-entry command holding register with load/pop and valid flag
module run_cmd_slot
  import run_gen_pkg::*;
#(
  parameter int W = 2 * RG_CNT_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         i_load,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/run_pattern_gen.sv
// rtl/run_pattern_gen.sv - serial run/gap pattern transmitter with detector reference output
module run_pattern_gen
  import run_gen_pkg::*;
#(
  parameter int CNT_W         = RG_CNT_W,
  parameter int DETECT_THRESH = RG_DETECT_THRESH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [CNT_W-1:0] CmdRun,
  input  logic [CNT_W-1:0] CmdGap,
  output logic             Data,
  output logic             Expect,
  output logic             Busy,
  output logic             Done
);

  typedef struct packed {
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] gap;
  } cmd_t;

  localparam int ONES_MAX = DETECT_THRESH + 1;
  localparam int ONES_W   = $clog2(ONES_MAX + 1);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [ONES_W-1:0] ONES_SAT = ONES_W'(ONES_MAX);
  localparam logic [ONES_W-1:0] ONES_THR = ONES_W'(DETECT_THRESH);

  state_t            r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_run_left, w_nxt_run_left;
  logic [CNT_W-1:0]  r_gap_left, w_nxt_gap_left;
  logic [ONES_W-1:0] r_ones, w_nxt_ones;
  logic              r_data, r_expect, r_done;
  logic              w_nxt_done, w_nxt_expect;

  cmd_t w_in_cmd, w_pend_cmd, w_load_cmd;
  logic w_pend_valid, w_accept, w_advance, w_load, w_pend_load, w_pend_pop;

  assign w_in_cmd   = {CmdRun, CmdGap};
  assign CmdReady   = !w_pend_valid && !Reset;
  assign w_accept   = CmdValid && CmdReady;
  // r_done marks the final bit on Data, so the next command may take over at this edge
  assign w_advance  = (r_state == IDLE) || r_done;
  assign w_pend_pop = w_advance && w_pend_valid;
  assign w_pend_load = w_accept && !w_advance;
  assign w_load     = w_pend_pop || (w_accept && w_advance);
  assign w_load_cmd = w_pend_valid ? w_pend_cmd : w_in_cmd;

  run_cmd_slot #(.W(2 * CNT_W)) u_pend (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_load  (w_pend_load),
    .i_pop   (w_pend_pop),
    .i_data  (w_in_cmd),
    .o_valid (w_pend_valid),
    .o_data  (w_pend_cmd)
  );

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_run_left = r_run_left;
    w_nxt_gap_left = r_gap_left;
    if (w_advance) begin
      if (!w_load) begin
        w_nxt_state    = IDLE;
        w_nxt_run_left = '0;
        w_nxt_gap_left = '0;
      end else if (w_load_cmd.run != '0) begin
        w_nxt_state    = RUN;
        w_nxt_run_left = w_load_cmd.run;
        w_nxt_gap_left = w_load_cmd.gap;
      end else begin
        // an empty {0,0} command still occupies one zero bit so it can carry Done
        w_nxt_state    = GAP;
        w_nxt_run_left = '0;
        w_nxt_gap_left = (w_load_cmd.gap == '0) ? ONE : w_load_cmd.gap;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (r_run_left == ONE) begin
            w_nxt_state    = GAP;
            w_nxt_run_left = '0;
          end else begin
            w_nxt_run_left = r_run_left - ONE;
          end
        end
        GAP:     w_nxt_gap_left = r_gap_left - ONE;
        default: w_nxt_state    = IDLE;
      endcase
    end
  end

  always_comb begin
    w_nxt_done = 1'b0;
    w_nxt_ones = '0;
    if (w_nxt_state == RUN) begin
      w_nxt_done = (w_nxt_run_left == ONE) && (w_nxt_gap_left == '0);
      w_nxt_ones = (r_ones == ONES_SAT) ? r_ones : r_ones + 1'b1;
    end else if (w_nxt_state == GAP) begin
      w_nxt_done = (w_nxt_gap_left == ONE);
    end
    w_nxt_expect = (w_nxt_ones > ONES_THR);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_run_left <= '0;
      r_gap_left <= '0;
      r_ones     <= '0;
      r_data     <= 1'b0;
      r_expect   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_run_left <= w_nxt_run_left;
      r_gap_left <= w_nxt_gap_left;
      r_ones     <= w_nxt_ones;
      r_data     <= (w_nxt_state == RUN);
      r_expect   <= w_nxt_expect;
      r_done     <= w_nxt_done;
    end
  end

  assign Data   = r_data;
  assign Expect = r_expect;
  assign Done   = r_done;
  assign Busy   = (r_state != IDLE) || w_pend_valid;

endmodule
